// File: rtl/regfile_scoreboard.sv
// Integer register file with a pending-bit scoreboard for the ALU operand side.
// Reads are combinational with same-cycle writeback bypass. Each issued destination
// is marked pending until its writeback arrives, and issue stalls on RAW/WAW hazards.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1_addr,
  input  logic [AW-1:0]   issue_rs2_addr,
  input  logic [AW-1:0]   issue_rd_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     pending_cnt,
  output logic            wb_err
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_next;
  logic             wb_live;
  logic             accept;
  logic             hit_rs1;
  logic             hit_rs2;
  logic             hit_rd;

  // Number of set bits; bit 0 is never set, so the result stays below NREGS.
  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // A writeback to x0 is discarded everywhere: no write, no clear, no error.
  assign wb_live = wb_valid && (wb_addr != '0);

  // Operand read port 1: x0 is zero, then same-cycle writeback, then the array.
  always_comb begin
    rs1_data = regs[issue_rs1_addr];
    if (issue_rs1_addr == '0) begin
      rs1_data = '0;
    end else if (wb_valid && (wb_addr == issue_rs1_addr)) begin
      rs1_data = wb_data;
    end
  end

  // Operand read port 2: same priority as port 1.
  always_comb begin
    rs2_data = regs[issue_rs2_addr];
    if (issue_rs2_addr == '0) begin
      rs2_data = '0;
    end else if (wb_valid && (wb_addr == issue_rs2_addr)) begin
      rs2_data = wb_data;
    end
  end

  // Hazard check: a pending register is not a hazard if its writeback lands this cycle.
  always_comb begin
    hit_rs1 = wb_live && (wb_addr == issue_rs1_addr);
    hit_rs2 = wb_live && (wb_addr == issue_rs2_addr);
    hit_rd  = wb_live && (wb_addr == issue_rd_addr);
    stall   = issue_valid &&
              ((pend[issue_rs1_addr] && !hit_rs1) ||
               (pend[issue_rs2_addr] && !hit_rs2) ||
               (pend[issue_rd_addr]  && !hit_rd));
    accept  = issue_valid && !stall;
  end

  // Next pending set: writeback clears first so a same-edge issue to that address wins.
  always_comb begin
    pend_next = pend;
    if (wb_live) begin
      pend_next[wb_addr] = 1'b0;
    end
    if (accept && (issue_rd_addr != '0)) begin
      pend_next[issue_rd_addr] = 1'b1;
    end
  end

  // Scoreboard state, its registered population count, and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      pend        <= pend_next;
      pending_cnt <= popcount(pend_next);
      if (wb_live && !pend[wb_addr]) begin
        wb_err <= 1'b1;
      end
    end
  end

  // Register array writeback; x0 is never written and keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with an expectation queue.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk;
  logic            rst_n;
  logic            issue_valid;
  logic [AW-1:0]   issue_rs1_addr;
  logic [AW-1:0]   issue_rs2_addr;
  logic [AW-1:0]   issue_rd_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [AW:0]     pending_cnt;
  logic            wb_err;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_rs1_addr (issue_rs1_addr),
    .issue_rs2_addr (issue_rs2_addr),
    .issue_rd_addr  (issue_rd_addr),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .pending_cnt    (pending_cnt),
    .wb_err         (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%0h required=an expectation", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic v, input int rs1, input int rs2, input int rd);
    issue_valid    = v;
    issue_rs1_addr = AW'(rs1);
    issue_rs2_addr = AW'(rs2);
    issue_rd_addr  = AW'(rd);
  endtask

  task automatic drive_wb(input logic v, input int a, input logic [XLEN-1:0] d);
    wb_valid = v;
    wb_addr  = AW'(a);
    wb_data  = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive_issue(1'b0, 0, 0, 0);
    drive_wb(1'b0, 0, '0);

    // Reset: hold low for a few edges, release between edges.
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    for (int a = 0; a < NREGS; a++) begin
      drive_issue(1'b0, a, NREGS - 1 - a, 0);
      #1;
      push("reset_rs1", 64'h0);
      pop_check({32'h0, rs1_data});
      push("reset_rs2", 64'h0);
      pop_check({32'h0, rs2_data});
    end
    push("reset_cnt", 64'd0);
    pop_check({58'h0, pending_cnt});
    push("reset_err", 64'd0);
    pop_check({63'h0, wb_err});
    push("reset_stall", 64'd0);
    pop_check({63'h0, stall});

    // x0 protection: first writeback after reset targets x0, no error.
    tick();
    drive_wb(1'b1, 0, 32'hDEADBEEF);
    drive_issue(1'b0, 0, 0, 0);
    tick();
    drive_wb(1'b0, 0, '0);
    #1;
    push("x0_read", 64'h0);
    pop_check({32'h0, rs1_data});
    push("x0_err", 64'd0);
    pop_check({63'h0, wb_err});
    drive_issue(1'b1, 0, 0, 0);
    #1;
    push("x0_issue_stall", 64'd0);
    pop_check({63'h0, stall});
    tick();
    drive_issue(1'b0, 0, 0, 0);
    push("x0_issue_cnt", 64'd0);
    pop_check({58'h0, pending_cnt});

    // RAW: mark x5 pending, then a dependent issue stalls until its writeback.
    drive_issue(1'b1, 1, 2, 5);
    #1;
    push("raw_first_stall", 64'd0);
    pop_check({63'h0, stall});
    tick();
    push("raw_cnt_set", 64'd1);
    pop_check({58'h0, pending_cnt});
    drive_issue(1'b1, 5, 0, 0);
    #1;
    push("raw_stall", 64'd1);
    pop_check({63'h0, stall});
    drive_wb(1'b1, 5, 32'h00000010);
    #1;
    push("raw_bypass_stall", 64'd0);
    pop_check({63'h0, stall});
    push("raw_bypass_data", 64'h10);
    pop_check({32'h0, rs1_data});
    tick();
    drive_issue(1'b0, 5, 0, 0);
    drive_wb(1'b0, 0, '0);
    #1;
    push("raw_cnt_clear", 64'd0);
    pop_check({58'h0, pending_cnt});
    push("raw_regs_x5", 64'h10);
    pop_check({32'h0, rs1_data});
    push("raw_err", 64'd0);
    pop_check({63'h0, wb_err});

    // WAW with simultaneous set and clear of x7.
    drive_issue(1'b1, 0, 0, 7);
    tick();
    drive_issue(1'b1, 0, 0, 7);
    #1;
    push("waw_stall", 64'd1);
    pop_check({63'h0, stall});
    drive_wb(1'b1, 7, 32'h00000077);
    #1;
    push("waw_hit_stall", 64'd0);
    pop_check({63'h0, stall});
    tick();
    drive_wb(1'b0, 0, '0);
    #1;
    push("waw_cnt", 64'd1);
    pop_check({58'h0, pending_cnt});
    push("waw_still_pending", 64'd1);
    pop_check({63'h0, stall});
    drive_issue(1'b0, 7, 0, 0);
    drive_wb(1'b1, 7, 32'h00000078);
    tick();
    drive_wb(1'b0, 0, '0);
    #1;
    push("waw_cnt_clear", 64'd0);
    pop_check({58'h0, pending_cnt});
    push("waw_x7", 64'h78);
    pop_check({32'h0, rs1_data});

    // Set and clear of different addresses on one edge keeps the count.
    drive_issue(1'b1, 0, 0, 3);
    tick();
    drive_issue(1'b1, 0, 0, 4);
    drive_wb(1'b1, 3, 32'h33);
    tick();
    drive_issue(1'b0, 0, 0, 0);
    drive_wb(1'b0, 0, '0);
    push("diff_setclr_cnt", 64'd1);
    pop_check({58'h0, pending_cnt});
    drive_wb(1'b1, 4, 32'h44);
    tick();
    drive_wb(1'b0, 0, '0);
    push("diff_clear_cnt", 64'd0);
    pop_check({58'h0, pending_cnt});
    push("diff_err", 64'd0);
    pop_check({63'h0, wb_err});

    // Spurious writeback to non-pending x9.
    drive_wb(1'b1, 9, 32'h12345678);
    tick();
    drive_wb(1'b0, 0, '0);
    drive_issue(1'b0, 9, 4, 0);
    #1;
    push("spur_err", 64'd1);
    pop_check({63'h0, wb_err});
    push("spur_x9", 64'h12345678);
    pop_check({32'h0, rs1_data});
    push("spur_x4", 64'h44);
    pop_check({32'h0, rs2_data});
    tick();
    push("spur_err_sticky", 64'd1);
    pop_check({63'h0, wb_err});

    // Async reset with three registers pending.
    drive_issue(1'b1, 0, 0, 10);
    tick();
    drive_issue(1'b1, 0, 0, 11);
    tick();
    drive_issue(1'b1, 0, 0, 12);
    tick();
    drive_issue(1'b1, 10, 9, 0);
    #1;
    push("pre_rst_cnt", 64'd3);
    pop_check({58'h0, pending_cnt});
    push("pre_rst_stall", 64'd1);
    pop_check({63'h0, stall});
    #1 rst_n = 1'b0;
    #1;
    push("arst_cnt", 64'd0);
    pop_check({58'h0, pending_cnt});
    push("arst_stall", 64'd0);
    pop_check({63'h0, stall});
    push("arst_rs1", 64'h0);
    pop_check({32'h0, rs1_data});
    push("arst_rs2", 64'h0);
    pop_check({32'h0, rs2_data});
    push("arst_err", 64'd0);
    pop_check({63'h0, wb_err});
    drive_issue(1'b0, 0, 0, 0);
    #1 rst_n = 1'b1;
    tick();
    push("post_rst_cnt", 64'd0);
    pop_check({58'h0, pending_cnt});

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Integer register file on the operand side of the ALU.
- Supplies rs1/rs2 operand values to the ALU and accepts the ALU's registered rd result as writeback one cycle after issue.
- Tracks each issued-but-not-written destination in a pending-bit scoreboard and raises stall on read-after-write (RAW) and write-after-write (WAW) hazards.
- Forwards same-cycle writeback data directly to the read ports.

Parameters:
XLEN, 32, data width of each register and of the read/write data ports.
NREGS, 32, number of architectural registers; address width AW = $clog2(NREGS); register 0 is hardwired zero.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  an instruction is presenting operand addresses and a destination this cycle
issue_rs1_addr  input  AW  first source register address
issue_rs2_addr  input  AW  second source register address
issue_rd_addr  input  AW  destination register the issued instruction will write
rs1_data  output  XLEN  first operand value, combinational
rs2_data  output  XLEN  second operand value, combinational
stall  output  1  issue not accepted this cycle, combinational
wb_valid  input  1  ALU writeback valid
wb_addr  input  AW  writeback destination address
wb_data  input  XLEN  writeback value (ALU rd)
pending_cnt  output  AW+1  number of registers currently marked pending, registered
wb_err  output  1  sticky flag: writeback to a non-pending nonzero register, registered

Behaviour:
- Reset, asynchronous on rst_n low:
  - all registers 0; all pending bits 0; pending_cnt 0; wb_err 0.
  - rs1_data/rs2_data therefore read 0; stall 0.
  - Reset mid-operation discards any outstanding writeback tracking. A wb_valid in the first cycle after reset sets wb_err, unless wb_addr is 0.
- Reads, combinational, per port (port n = 1 or 2):
  - addr==0 -> 0.
  - else wb_valid && wb_addr==addr -> wb_data (bypass).
  - else regs[addr].
- Write at posedge: if wb_valid && wb_addr!=0, regs[wb_addr] <= wb_data. Writes to address 0 are ignored and never flag wb_err.
- Hazard detection:
  - hit_x means wb_valid && wb_addr==x && x!=0.
  - stall = issue_valid && ((pend[rs1] && !hit_rs1) || (pend[rs2] && !hit_rs2) || (pend[rd] && !hit_rd)).
  - stall is 0 whenever issue_valid is 0.
- Issue accept: issue_valid && !stall. On accept with issue_rd_addr!=0, pend[rd] <= 1 at the next posedge. rd==0 is never marked.
- Writeback clear: wb_valid && wb_addr!=0 clears pend[wb_addr].
  - If the same edge also accepts an issue to that address, set wins and the bit stays 1.
- wb_err: set at posedge when wb_valid && wb_addr!=0 && !pend[wb_addr] (value before update). Sticky until reset. The register write still happens.
- pending_cnt:
  - Registered popcount of pend after update.
  - Increments by 1 on accept-set alone; decrements by 1 on valid clear alone.
  - Unchanged on a simultaneous set and clear of the same address, or of different addresses.
  - Never exceeds NREGS-1.
- Latency:
  - Operand read: 0 cycles.
  - Write visible via regs: next cycle; via bypass: same cycle.
  - Matches the ALU's single registered stage, so back-to-back dependent ALU ops issue without a bubble when writeback is on time.

Test Plan:
- Reset: hold rst_n=0, then release. Read all 32 addresses -> all 0x00000000; pending_cnt=0; wb_err=0; stall=0.
- x0 protection: wb_valid, wb_addr=0, wb_data=0xDEADBEEF. Read x0 next cycle -> 0; wb_err stays 0. Issue rd=0 -> pending_cnt stays 0.
- RAW bubble and bypass:
  - Issue rd=5, rs1=1, rs2=2 -> accepted, pending_cnt=1.
  - Next cycle issue rs1=5 with wb_valid=0 -> stall=1.
  - Same issue with wb_valid, wb_addr=5, wb_data=0x00000010 -> stall=0, rs1_data=0x10, pending_cnt back to 0 after the edge.
- WAW plus simultaneous set/clear: pend[7]=1. Issue rd=7 while wb_addr=7 is valid -> accepted; pend[7] remains 1; pending_cnt unchanged (1).
- Spurious writeback: wb_valid, wb_addr=9, pend[9]=0, wb_data=0x12345678 -> wb_err=1 after the edge and stays 1; x9 reads 0x12345678.
- Async reset mid-flight: with 3 pending registers, pulse rst_n low between clock edges -> pending_cnt=0 immediately; stall=0; all reads return 0.
